// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants, ALU operations and pipeline bundles.
// Used by riscv_core and riscv_regfile; no ports.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_A_RS1,
        SRC_A_PC,
        SRC_A_ZERO
    } src_a_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        alu_op_e     alu_op;
        src_a_e      src_a;
        logic        src_b_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic [2:0]  funct3;
    } id_ex_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [31:0] result;
        logic [31:0] store_data;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        reg_write;
        logic [31:0] wdata;
    } mem_wb_t;

    // alt selects SUB over ADD and SRA over SRL.
    function automatic alu_op_e alu_sel(
        input logic [2:0] f3,
        input logic       alt
    );
        alu_op_e op;
        op = ALU_ADD;
        unique case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] alu_f(
        input alu_op_e     op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] r;
        logic [4:0]  sh;
        sh = b[4:0];
        unique case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a << sh;
            ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: r = {31'd0, a < b};
            ALU_XOR:  r = a ^ b;
            ALU_SRL:  r = a >> sh;
            ALU_SRA:  r = $signed(a) >>> sh;
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            default:  r = a + b;
        endcase
        return r;
    endfunction

    function automatic logic br_taken(
        input logic [2:0]  f3,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic t;
        unique case (f3)
            F3_BEQ:  t = (a == b);
            F3_BNE:  t = (a != b);
            F3_BLT:  t = ($signed(a) < $signed(b));
            F3_BGE:  t = ($signed(a) >= $signed(b));
            F3_BLTU: t = (a < b);
            F3_BGEU: t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/riscv_regfile.sv
// 32x32 register file: two combinational read ports, one write port.
// Ports: clk, rst (sync, active-low), rs1/rs2 addr+data, we/rd_addr/rd_data.
module riscv_regfile
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        we,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_data
);

    logic [31:0] register_file [0:31];
    logic        wr;

    assign wr = we && (rd_addr != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                register_file[i] <= '0;
            end
        end else if (wr) begin
            register_file[rd_addr] <= rd_data;
        end
    end

    // Same-cycle write is bypassed so ID sees the value WB is retiring.
    always_comb begin
        rs1_data = register_file[rs1_addr];
        rs2_data = register_file[rs2_addr];
        if (wr && rd_addr == rs1_addr) rs1_data = rd_data;
        if (wr && rd_addr == rs2_addr) rs2_data = rd_data;
        if (rs1_addr == 5'd0) rs1_data = '0;
        if (rs2_addr == 5'd0) rs2_data = '0;
    end

endmodule

// File: rtl/riscv_core.sv
// 5-stage in-order RV32I subset core (IF ID EX MEM WB).
// Ports: clk, rst (sync, active-low), inst_* fetch port, data_* memory port.
// Macro RISCV_FORWARDING_EN: EX operand forwarding; otherwise ID interlock.
module riscv_core
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] inst_addr_o,
    input  logic [31:0] inst_i,
    output logic        inst_ce_o,
    output logic        data_ce_o,
    output logic        data_we_o,
    output logic [31:0] data_addr_o,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    logic [31:0] pc;
    logic        run;
    if_id_t      if_id;
    id_ex_t      id_ex;
    id_ex_t      dec;
    ex_mem_t     ex_mem;
    mem_wb_t     mem_wb;

    logic        stall;
    logic        redirect;
    logic [31:0] target;

    // ---------------- IF ----------------
    // run lags reset release by one edge so the first fetch is RESET_PC.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc  <= RESET_PC;
            run <= 1'b0;
        end else begin
            run <= 1'b1;
            if (redirect) pc <= target;
            else if (run && !stall) pc <= pc + 32'd4;
        end
    end

    assign inst_addr_o = pc;
    assign inst_ce_o   = run;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if_id <= '0;
        end else if (redirect) begin
            if_id <= '0;
        end else if (!stall) begin
            if_id.valid <= run;
            if_id.pc    <= pc;
            if_id.inst  <= inst_i;
        end
    end

    // ---------------- ID ----------------
    logic [31:0] ins;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic        op_ok;
    logic        opimm_ok;
    logic        br_ok;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        use_rs1;
    logic        use_rs2;

    assign ins = if_id.inst;
    assign opc = ins[6:0];
    assign f3  = ins[14:12];
    assign f7  = ins[31:25];

    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7],
                    ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'd0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12],
                    ins[20], ins[30:21], 1'b0};

    assign op_ok = (f7 == F7_BASE) ||
                   (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
    assign opimm_ok = (f3 != F3_SLL || f7 == F7_BASE) &&
                      (f3 != F3_SR  || f7 == F7_BASE || f7 == F7_ALT);
    assign br_ok = (f3 != 3'b010) && (f3 != 3'b011);

    riscv_regfile RF (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (ins[19:15]),
        .rs2_addr (ins[24:20]),
        .rs1_data (rs1_val),
        .rs2_data (rs2_val),
        .we       (mem_wb.valid && mem_wb.reg_write),
        .rd_addr  (mem_wb.rd),
        .rd_data  (mem_wb.wdata)
    );

    // Unsupported encodings leave every control flag clear (NOP).
    always_comb begin
        dec         = '0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        dec.valid   = if_id.valid;
        dec.pc      = if_id.pc;
        dec.rs1_val = rs1_val;
        dec.rs2_val = rs2_val;
        dec.rs1     = ins[19:15];
        dec.rs2     = ins[24:20];
        dec.rd      = ins[11:7];
        dec.funct3  = f3;
        dec.alu_op  = ALU_ADD;
        dec.src_a   = SRC_A_RS1;
        if (if_id.valid) begin
            unique case (1'b1)
                opc == OPC_LUI: begin
                    dec.reg_write = 1'b1;
                    dec.src_a     = SRC_A_ZERO;
                    dec.src_b_imm = 1'b1;
                    dec.imm       = imm_u;
                end
                opc == OPC_AUIPC: begin
                    dec.reg_write = 1'b1;
                    dec.src_a     = SRC_A_PC;
                    dec.src_b_imm = 1'b1;
                    dec.imm       = imm_u;
                end
                opc == OPC_JAL: begin
                    dec.reg_write = 1'b1;
                    dec.jal       = 1'b1;
                    dec.imm       = imm_j;
                end
                opc == OPC_JALR && f3 == F3_JALR: begin
                    dec.reg_write = 1'b1;
                    dec.jalr      = 1'b1;
                    dec.imm       = imm_i;
                    use_rs1       = 1'b1;
                end
                opc == OPC_BRANCH && br_ok: begin
                    dec.branch = 1'b1;
                    dec.imm    = imm_b;
                    use_rs1    = 1'b1;
                    use_rs2    = 1'b1;
                end
                opc == OPC_LOAD && f3 == F3_LW: begin
                    dec.reg_write = 1'b1;
                    dec.mem_read  = 1'b1;
                    dec.src_b_imm = 1'b1;
                    dec.imm       = imm_i;
                    use_rs1       = 1'b1;
                end
                opc == OPC_STORE && f3 == F3_SW: begin
                    dec.mem_write = 1'b1;
                    dec.src_b_imm = 1'b1;
                    dec.imm       = imm_s;
                    use_rs1       = 1'b1;
                    use_rs2       = 1'b1;
                end
                opc == OPC_OPIMM && opimm_ok: begin
                    dec.reg_write = 1'b1;
                    dec.src_b_imm = 1'b1;
                    dec.imm       = imm_i;
                    dec.alu_op    = alu_sel(f3,
                                        f3 == F3_SR && f7[5]);
                    use_rs1       = 1'b1;
                end
                opc == OPC_OP && op_ok: begin
                    dec.reg_write = 1'b1;
                    dec.alu_op    = alu_sel(f3, f7[5]);
                    use_rs1       = 1'b1;
                    use_rs2       = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- hazards ----------------
    logic ex_hit;
    logic mem_hit;
    logic ld_use;

    always_comb begin
        ex_hit = id_ex.valid && id_ex.reg_write &&
                 id_ex.rd != 5'd0 &&
                 ((use_rs1 && id_ex.rd == dec.rs1) ||
                  (use_rs2 && id_ex.rd == dec.rs2));
        mem_hit = ex_mem.valid && ex_mem.reg_write &&
                  ex_mem.rd != 5'd0 &&
                  ((use_rs1 && ex_mem.rd == dec.rs1) ||
                   (use_rs2 && ex_mem.rd == dec.rs2));
        ld_use = ex_hit && id_ex.mem_read;
    end

`ifdef RISCV_FORWARDING_EN
    assign stall = if_id.valid && ld_use;
`else
    // Hold in ID until the producer is in WB (regfile bypass covers it).
    assign stall = if_id.valid && (ex_hit || mem_hit || ld_use);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            id_ex <= '0;
        end else if (redirect || stall) begin
            id_ex <= '0;
        end else begin
            id_ex <= dec;
        end
    end

    // ---------------- EX ----------------
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic        taken;

    always_comb begin
        fwd_a = id_ex.rs1_val;
        fwd_b = id_ex.rs2_val;
`ifdef RISCV_FORWARDING_EN
        if (ex_mem.valid && ex_mem.reg_write &&
            ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs1)
            fwd_a = ex_mem.result;
        else if (mem_wb.valid && mem_wb.reg_write &&
                 mem_wb.rd != 5'd0 && mem_wb.rd == id_ex.rs1)
            fwd_a = mem_wb.wdata;
        if (ex_mem.valid && ex_mem.reg_write &&
            ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs2)
            fwd_b = ex_mem.result;
        else if (mem_wb.valid && mem_wb.reg_write &&
                 mem_wb.rd != 5'd0 && mem_wb.rd == id_ex.rs2)
            fwd_b = mem_wb.wdata;
`endif
    end

    always_comb begin
        unique case (id_ex.src_a)
            SRC_A_PC:   op_a = id_ex.pc;
            SRC_A_ZERO: op_a = '0;
            default:    op_a = fwd_a;
        endcase
        op_b    = id_ex.src_b_imm ? id_ex.imm : fwd_b;
        alu_res = alu_f(id_ex.alu_op, op_a, op_b);
        taken   = id_ex.branch &&
                  br_taken(id_ex.funct3, fwd_a, fwd_b);
        redirect = id_ex.valid &&
                   (taken || id_ex.jal || id_ex.jalr);
        if (id_ex.jalr)
            target = (fwd_a + id_ex.imm) & 32'hFFFF_FFFE;
        else
            target = id_ex.pc + id_ex.imm;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_mem <= '0;
        end else begin
            ex_mem.valid      <= id_ex.valid;
            ex_mem.rd         <= id_ex.rd;
            ex_mem.reg_write  <= id_ex.reg_write;
            ex_mem.mem_read   <= id_ex.mem_read;
            ex_mem.mem_write  <= id_ex.mem_write;
            ex_mem.store_data <= fwd_b;
            ex_mem.result     <= (id_ex.jal || id_ex.jalr) ?
                                 id_ex.pc + 32'd4 : alu_res;
        end
    end

    // ---------------- MEM ----------------
    logic access;

    assign access      = ex_mem.valid &&
                         (ex_mem.mem_read || ex_mem.mem_write);
    assign data_ce_o   = access;
    assign data_we_o   = ex_mem.valid && ex_mem.mem_write;
    assign data_addr_o = access ? ex_mem.result : '0;
    assign data_o      = data_we_o ? ex_mem.store_data : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_wb <= '0;
        end else begin
            mem_wb.valid     <= ex_mem.valid;
            mem_wb.rd        <= ex_mem.rd;
            mem_wb.reg_write <= ex_mem.reg_write;
            mem_wb.wdata     <= ex_mem.mem_read ?
                                data_i : ex_mem.result;
        end
    end

endmodule

// File: tb/tb_riscv_core.sv
// Directed bench for riscv_core: small programs, register table checks.
module tb_riscv_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_i;
    logic        inst_ce_o;
    logic        data_ce_o;
    logic        data_we_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_i;
    logic [31:0] data_o;

    riscv_core dut (
        .clk         (clk),
        .rst         (rst),
        .inst_addr_o (inst_addr_o),
        .inst_i      (inst_i),
        .inst_ce_o   (inst_ce_o),
        .data_ce_o   (data_ce_o),
        .data_we_o   (data_we_o),
        .data_addr_o (data_addr_o),
        .data_i      (data_i),
        .data_o      (data_o)
    );

    always #5 clk = ~clk;

    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:63];

    assign inst_i = imem[inst_addr_o[7:2]];
    assign data_i = dmem[data_addr_o[7:2]];

    always @(posedge clk) begin
        if (data_we_o) dmem[data_addr_o[7:2]] <= data_o;
    end

    int          n_checks = 0;
    int          n_pass = 0;
    int          we_cnt = 0;
    int          ce_cnt = 0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;

    always @(negedge clk) begin
        if (rst && data_we_o) begin
            we_cnt  <= we_cnt + 1;
            st_addr <= data_addr_o;
            st_data <= data_o;
        end
        if (rst && data_ce_o) ce_cnt <= ce_cnt + 1;
    end

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] e_i(input logic [11:0] imm,
        input logic [4:0] rs1, input logic [2:0] f3,
        input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] e_r(input logic [6:0] f7,
        input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] e_s(input logic [11:0] imm,
        input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] e_b(input logic [12:0] imm,
        input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3,
                imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] e_j(input logic [20:0] imm,
        input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd,
        input logic [4:0] rs1, input logic [11:0] imm);
        return e_i(imm, rs1, 3'd0, rd, 7'h13);
    endfunction

    task automatic put_end(input int a);
        imem[a]   = {20'h0, 5'd31, 7'h37};
        imem[a+1] = addi(5'd31, 5'd31, 12'h3FF);
        imem[a+2] = e_j(21'd0, 5'd0);
    endtask

    task automatic load_prog(input int p);
        for (int i = 0; i < 64; i++) begin
            imem[i] = NOP;
            dmem[i] = '0;
        end
        case (p)
            1: begin
                imem[0] = addi(5'd1, 5'd0, 12'd5);
                imem[1] = addi(5'd2, 5'd1, 12'd3);
                put_end(2);
            end
            2: begin
                imem[0] = addi(5'd2, 5'd0, 12'd8);
                imem[1] = e_s(12'd4, 5'd2, 5'd0, 3'd2);
                imem[2] = e_i(12'd4, 5'd0, 3'd2, 5'd3, 7'h03);
                imem[3] = e_r(7'h00, 5'd3, 5'd3, 3'd0, 5'd4);
                put_end(4);
            end
            3: begin
                imem[0] = addi(5'd1, 5'd0, 12'd1);
                imem[1] = e_b(13'd12, 5'd1, 5'd1, 3'd0);
                imem[2] = addi(5'd5, 5'd0, 12'd7);
                imem[3] = addi(5'd6, 5'd0, 12'd7);
                imem[4] = addi(5'd7, 5'd0, 12'd9);
                put_end(5);
            end
            4: begin
                imem[4] = e_j(21'd8, 5'd1);
                imem[5] = addi(5'd8, 5'd0, 12'd1);
                imem[6] = addi(5'd0, 5'd0, 12'd5);
                put_end(7);
            end
            default: begin
                dmem[0]  = 32'hA5A5_A5A5;
                imem[0]  = {20'h12345, 5'd10, 7'h37};
                imem[1]  = addi(5'd11, 5'd0, 12'hFFF);
                imem[2]  = e_i(12'd28, 5'd11, 3'd5, 5'd12, 7'h13);
                imem[3]  = e_i(12'h404, 5'd11, 3'd5, 5'd13, 7'h13);
                imem[4]  = e_r(7'h00, 5'd11, 5'd0, 3'd3, 5'd14);
                imem[5]  = e_r(7'h00, 5'd0, 5'd11, 3'd2, 5'd15);
                imem[6]  = e_r(7'h20, 5'd11, 5'd0, 3'd0, 5'd16);
                imem[7]  = {20'h00001, 5'd18, 7'h17};
                imem[8]  = addi(5'd20, 5'd0, 12'd7);
                imem[9]  = e_i(12'd0, 5'd0, 3'd0, 5'd20, 7'h03);
                imem[10] = e_s(12'd0, 5'd11, 5'd0, 3'd0);
                imem[11] = addi(5'd21, 5'd0, 12'h039);
                imem[12] = e_i(12'd0, 5'd21, 3'd0, 5'd19, 7'h67);
                imem[13] = addi(5'd22, 5'd0, 12'd1);
                imem[14] = e_r(7'h00, 5'd11, 5'd10, 3'd0, 5'd23);
                imem[15] = e_b(13'd8, 5'd0, 5'd0, 3'd1);
                imem[16] = addi(5'd24, 5'd0, 12'd3);
                put_end(17);
            end
        endcase
    endtask

    task automatic check(input string name,
        input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic run_prog(input int p);
        logic done;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load_prog(p);
        repeat (2) @(negedge clk);
        check("rst_inst_ce", {31'd0, inst_ce_o}, 32'd0);
        check("rst_data_ce", {31'd0, data_ce_o}, 32'd0);
        check("rst_data_we", {31'd0, data_we_o}, 32'd0);
        check("rst_data_addr", data_addr_o, 32'd0);
        we_cnt = 0;
        ce_cnt = 0;
        rst = 1'b1;
        @(negedge clk);
        check("first_fetch_ce", {31'd0, inst_ce_o}, 32'd1);
        check("first_fetch_addr", inst_addr_o, 32'd0);
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (dut.RF.register_file[31] == 32'h3FF) done = 1'b1;
        end
        check($sformatf("p%0d_complete", p), {31'd0, done}, 32'd1);
    endtask

    typedef struct {
        int          prog;
        int          rn;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int p, input int r,
        input logic [31:0] e);
        vec_t v;
        v.prog = p;
        v.rn   = r;
        v.exp  = e;
        vecs.push_back(v);
    endfunction

    task automatic check_regs(input int p);
        foreach (vecs[i]) begin
            if (vecs[i].prog == p)
                check($sformatf("p%0d_x%0d", p, vecs[i].rn),
                      dut.RF.register_file[vecs[i].rn], vecs[i].exp);
        end
    endtask

    initial begin
        logic [31:0] sum;
        add(1, 1, 32'd5);
        add(1, 2, 32'd8);
        add(2, 2, 32'd8);
        add(2, 3, 32'd8);
        add(2, 4, 32'd16);
        add(3, 1, 32'd1);
        add(3, 5, 32'd0);
        add(3, 6, 32'd0);
        add(3, 7, 32'd9);
        add(4, 1, 32'h14);
        add(4, 0, 32'd0);
        add(4, 8, 32'd0);
        add(4, 31, 32'h3FF);
        add(5, 10, 32'h1234_5000);
        add(5, 11, 32'hFFFF_FFFF);
        add(5, 12, 32'h0000_000F);
        add(5, 13, 32'hFFFF_FFFF);
        add(5, 14, 32'd1);
        add(5, 15, 32'd1);
        add(5, 16, 32'd1);
        add(5, 18, 32'h0000_101C);
        add(5, 19, 32'h0000_0034);
        add(5, 20, 32'd7);
        add(5, 21, 32'h39);
        add(5, 22, 32'd0);
        add(5, 23, 32'h1234_4FFF);
        add(5, 24, 32'd3);

        run_prog(1);
        check_regs(1);

        // Reset in the middle of program 2 must wipe all state.
        rst = 1'b0;
        @(negedge clk);
        load_prog(2);
        @(negedge clk);
        rst = 1'b1;
        repeat (7) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            sum = '0;
            for (int r = 0; r < 32; r++)
                sum = sum | dut.RF.register_file[r];
            check("midrst_regs_zero", sum, 32'd0);
            check("midrst_we", {31'd0, data_we_o}, 32'd0);
        end

        run_prog(2);
        check_regs(2);
        check("p2_store_count", we_cnt, 32'd1);
        check("p2_store_addr", st_addr, 32'd4);
        check("p2_store_data", st_data, 32'd8);
        check("p2_dmem1", dmem[1], 32'd8);

        run_prog(3);
        check_regs(3);

        run_prog(4);
        check_regs(4);

        run_prog(5);
        check_regs(5);
        check("p5_store_count", we_cnt, 32'd0);
        check("p5_access_count", ce_cnt, 32'd0);
        check("p5_dmem0", dmem[0], 32'hA5A5_A5A5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
